// File: rtl/piano_pkg.sv
// Shared note codes, octave limits, FSM state type and key priority encoder
// for the piano key control block.
package piano_pkg;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_C    = 3'd1;
    localparam logic [2:0] NOTE_D    = 3'd2;
    localparam logic [2:0] NOTE_E    = 3'd3;
    localparam logic [2:0] NOTE_F    = 3'd4;
    localparam logic [2:0] NOTE_G    = 3'd5;
    localparam logic [2:0] NOTE_A    = 3'd6;
    localparam logic [2:0] NOTE_B    = 3'd7;

    localparam int              OCT_W   = 2;
    localparam logic [OCT_W-1:0] OCT_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Lowest key index wins: c > d > e > f > g > a > b.
    function automatic logic [2:0] prio_code(input logic [6:0] k);
        logic [2:0] code;
        if      (k[0]) code = NOTE_C;
        else if (k[1]) code = NOTE_D;
        else if (k[2]) code = NOTE_E;
        else if (k[3]) code = NOTE_F;
        else if (k[4]) code = NOTE_G;
        else if (k[5]) code = NOTE_A;
        else if (k[6]) code = NOTE_B;
        else           code = NOTE_NONE;
        return code;
    endfunction

endpackage

// File: rtl/note_key_ctrl_if.sv
// Key/button inputs and tone/display outputs of note_key_ctrl, bundled so the
// input driver (master) and the controller (slave) share one connection.
interface note_key_ctrl_if;

    logic [6:0]                  keys_i;
    logic                        up_i;
    logic                        down_i;
    logic [2:0]                  note_o;
    logic [piano_pkg::OCT_W-1:0] octave_o;
    logic                        gate_o;
    logic                        note_on_o;
    logic                        busy_o;

    modport master (
        output keys_i, up_i, down_i,
        input  note_o, octave_o, gate_o, note_on_o, busy_o
    );

    modport slave (
        input  keys_i, up_i, down_i,
        output note_o, octave_o, gate_o, note_on_o, busy_o
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability counter: the output follows
// the synchronized input only after DEB_CYCLES consecutive differing samples.
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                deb_reg <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign deb = deb_reg;

endmodule

// File: rtl/note_key_ctrl.sv
// Piano key controller: debounce, note priority, saturating octave and
// gate/release sequencing. Define OCT_REPEAT_EN for held-button octave auto-repeat.
module note_key_ctrl
    import piano_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int REL_CYCLES    = 64,
    parameter int OCT_RESET     = 1,
    parameter int REPEAT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    note_key_ctrl_if.slave  bus
);

    localparam int REL_W = $clog2(REL_CYCLES + 1);

    logic [8:0] raw_vec;
    logic [8:0] deb_vec;

    assign raw_vec = {bus.down_i, bus.up_i, bus.keys_i};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_deb
            key_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_vec[gi]),
                .deb   (deb_vec[gi])
            );
        end
    endgenerate

    logic [2:0] win_code;
    logic       up_deb;
    logic       dn_deb;

    assign win_code = prio_code(deb_vec[6:0]);
    assign up_deb   = deb_vec[7];
    assign dn_deb   = deb_vec[8];

    // Octave stepping from debounced edges (and optional auto-repeat).
    logic             up_q_reg;
    logic             dn_q_reg;
    logic             up_rise;
    logic             dn_rise;
    logic             rep_up;
    logic             rep_dn;
    logic             step_up;
    logic             step_dn;
    logic [OCT_W-1:0] octave_reg;
    logic [OCT_W-1:0] octave_next;
    logic             oct_change;

    assign up_rise = up_deb & ~up_q_reg;
    assign dn_rise = dn_deb & ~dn_q_reg;

`ifdef OCT_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic             hold_one;
    logic             rep_fire;

    // Only a single button held alone repeats; any fresh edge restarts the interval.
    assign hold_one = up_deb ^ dn_deb;
    assign rep_fire = hold_one && !(up_rise || dn_rise) &&
                      (rep_cnt_reg == REP_W'(REPEAT_CYCLES - 1));
    assign rep_up   = rep_fire & up_deb;
    assign rep_dn   = rep_fire & dn_deb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_reg <= '0;
        end else if (!hold_one || up_rise || dn_rise || rep_fire) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_repeat;

    assign unused_repeat = ^REPEAT_CYCLES;
    assign rep_up        = 1'b0;
    assign rep_dn        = 1'b0;
`endif

    assign step_up = (up_rise & ~dn_rise) | rep_up;
    assign step_dn = (dn_rise & ~up_rise) | rep_dn;

    always_comb begin
        octave_next = octave_reg;
        if (step_up && octave_reg != OCT_MAX) begin
            octave_next = octave_reg + 1'b1;
        end else if (step_dn && octave_reg != '0) begin
            octave_next = octave_reg - 1'b1;
        end
    end

    assign oct_change = (octave_next != octave_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_q_reg   <= 1'b0;
            dn_q_reg   <= 1'b0;
            octave_reg <= OCT_W'(OCT_RESET);
        end else begin
            up_q_reg   <= up_deb;
            dn_q_reg   <= dn_deb;
            octave_reg <= octave_next;
        end
    end

    // Gate sequencer; all outputs are registered alongside the state.
    state_t           state_reg;
    logic [2:0]       note_reg;
    logic             gate_reg;
    logic             note_on_reg;
    logic             busy_reg;
    logic [REL_W-1:0] rel_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            note_reg    <= NOTE_NONE;
            gate_reg    <= 1'b0;
            note_on_reg <= 1'b0;
            busy_reg    <= 1'b0;
            rel_cnt_reg <= '0;
        end else begin
            note_on_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_code != NOTE_NONE) begin
                        state_reg   <= HOLD;
                        note_reg    <= win_code;
                        gate_reg    <= 1'b1;
                        note_on_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (win_code == NOTE_NONE) begin
                        state_reg   <= RELEASE;
                        rel_cnt_reg <= REL_W'(REL_CYCLES - 1);
                        note_on_reg <= oct_change;
                    end else begin
                        note_reg    <= win_code;
                        note_on_reg <= (win_code != note_reg) || oct_change;
                    end
                end
                RELEASE: begin
                    if (win_code != NOTE_NONE) begin
                        state_reg   <= HOLD;
                        note_reg    <= win_code;
                        note_on_reg <= 1'b1;
                    end else if (rel_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        note_reg  <= NOTE_NONE;
                        gate_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else begin
                        rel_cnt_reg <= rel_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    note_reg  <= NOTE_NONE;
                    gate_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.note_o    = note_reg;
    assign bus.octave_o  = octave_reg;
    assign bus.gate_o    = gate_reg;
    assign bus.note_on_o = note_on_reg;
    assign bus.busy_o    = busy_reg;

endmodule
